data_check_s: RTL and testbench

DATA_CHECK_S -- requirements
Module: data_check_s

---
 rtl/data_check_s.sv | 135 +++++++++++++
 tb/tb_data_check_s.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_check_s.sv
// rtl/data_check_s.sv - block-pattern checker with SYNC/CHECK alignment FSM
// Optional macro CHK_HEADER_EN enables comparison of the position-0 block-index byte.
module data_check_s #(
   parameter int LOSS_THR = 4
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic [7:0]  data_in,
   input  logic        data_en,
   input  logic        clr_err,
   output logic        locked,
   output logic        err_flag,
   output logic [15:0] err_cnt,
   output logic [15:0] blk_cnt,
   output logic        blk_done
);

   typedef enum logic {SYNC, CHECK} state_t;

   localparam logic [3:0] THR = LOSS_THR[3:0];

   state_t      state, state_nxt;
   logic [7:0]  in_data;
   logic        in_en, in_clr;
   logic        armed, armed_nxt;
   logic [7:0]  pos, pos_nxt;
   logic [7:0]  blk_idx, idx_nxt;
   logic [3:0]  miss_cnt, miss_nxt;
   logic [7:0]  exp_byte;
   logic        pos_chk;
   logic        mismatch;
   logic        done_nxt;

   // Input stage gives the fixed one-cycle latency from sampled byte to outputs.
   always_ff @(posedge clk) begin
      if (!nRST) begin
         in_data <= 8'd0;
         in_en   <= 1'b0;
         in_clr  <= 1'b0;
      end else begin
         in_data <= data_in;
         in_en   <= data_en;
         in_clr  <= clr_err;
      end
   end

   assign exp_byte = (pos == 8'd0) ? blk_idx : pos;

`ifdef CHK_HEADER_EN
   assign pos_chk = 1'b1;
`else
   assign pos_chk = (pos != 8'd0);
`endif

   always_comb begin
      state_nxt = state;
      armed_nxt = armed;
      pos_nxt   = pos;
      idx_nxt   = blk_idx;
      miss_nxt  = miss_cnt;
      mismatch  = 1'b0;
      done_nxt  = 1'b0;
      if (in_en) begin
         case (state)
            SYNC: begin
               if (armed) begin
                  idx_nxt   = in_data;
                  pos_nxt   = 8'd1;
                  armed_nxt = 1'b0;
                  miss_nxt  = 4'd0;
                  state_nxt = CHECK;
               end else if (in_data == 8'd255) begin
                  armed_nxt = 1'b1;
               end
            end
            CHECK: begin
               mismatch = pos_chk && (in_data != exp_byte);
               pos_nxt  = pos + 8'd1;
               if (pos == 8'd255) begin
                  idx_nxt  = blk_idx + 8'd1;
                  done_nxt = 1'b1;
               end
               if (mismatch) begin
                  if (miss_cnt + 4'd1 == THR) begin
                     state_nxt = SYNC;
                     armed_nxt = 1'b0;
                     pos_nxt   = 8'd0;
                     miss_nxt  = 4'd0;
                  end else begin
                     miss_nxt = miss_cnt + 4'd1;
                  end
               end else begin
                  miss_nxt = 4'd0;
               end
            end
            default: state_nxt = SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nRST) begin
         state    <= SYNC;
         armed    <= 1'b0;
         pos      <= 8'd0;
         blk_idx  <= 8'd0;
         miss_cnt <= 4'd0;
         locked   <= 1'b0;
         err_flag <= 1'b0;
         err_cnt  <= 16'd0;
         blk_cnt  <= 16'd0;
         blk_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         armed    <= armed_nxt;
         pos      <= pos_nxt;
         blk_idx  <= idx_nxt;
         miss_cnt <= miss_nxt;
         locked   <= (state_nxt == CHECK);
         blk_done <= done_nxt;
         if (done_nxt)
            blk_cnt <= blk_cnt + 16'd1;
         // A mismatch coincident with clear leaves a count of one.
         if (in_clr) begin
            err_flag <= mismatch;
            err_cnt  <= mismatch ? 16'd1 : 16'd0;
         end else if (mismatch) begin
            err_flag <= 1'b1;
            if (err_cnt != 16'hFFFF)
               err_cnt <= err_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_data_check_s.sv
// tb/tb_data_check_s.sv - scoreboard bench for data_check_s
module tb_data_check_s;

   logic        clk = 1'b0;
   logic        nRST = 1'b0;
   logic [7:0]  data_in = 8'd0;
   logic        data_en = 1'b0;
   logic        clr_err = 1'b0;
   logic        locked, err_flag, blk_done;
   logic [15:0] err_cnt, blk_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] blk_cnt;
      logic [15:0] err_cnt;
      logic        err_flag;
      logic        locked;
   } exp_t;

   exp_t sb[$];

`ifdef CHK_HEADER_EN
   localparam logic [15:0] HDR_ERR = 16'd1;
`else
   localparam logic [15:0] HDR_ERR = 16'd0;
`endif

   data_check_s #(.LOSS_THR(4)) dut (
      .clk      (clk),
      .nRST     (nRST),
      .data_in  (data_in),
      .data_en  (data_en),
      .clr_err  (clr_err),
      .locked   (locked),
      .err_flag (err_flag),
      .err_cnt  (err_cnt),
      .blk_cnt  (blk_cnt),
      .blk_done (blk_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every blk_done pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (nRST && blk_done) begin
         if (sb.size() == 0) begin
            check("unexpected_blk_done", 16'd1, 16'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("blk_cnt", blk_cnt, e.blk_cnt);
            check("blk_err_cnt", err_cnt, e.err_cnt);
            check("blk_err_flag", {15'd0, err_flag}, {15'd0, e.err_flag});
            check("blk_locked", {15'd0, locked}, {15'd0, e.locked});
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic en, input logic clr);
      @(negedge clk);
      data_in = b;
      data_en = en;
      clr_err = clr;
   endtask

   task automatic idle(input int n);
      repeat (n) send(8'd0, 1'b0, 1'b0);
   endtask

   task automatic expect_blk(input logic [15:0] bc, input logic [15:0] ec, input logic ef);
      exp_t e;
      e.blk_cnt  = bc;
      e.err_cnt  = ec;
      e.err_flag = ef;
      e.locked   = 1'b1;
      sb.push_back(e);
   endtask

   // Positions 1..255; positions in [bad_lo, bad_hi] are sent as 8'h00.
   task automatic body(input int bad_lo, input int bad_hi, input bit gaps);
      for (int p = 1; p < 256; p++) begin
         send((p >= bad_lo && p <= bad_hi) ? 8'h00 : 8'(p), 1'b1, 1'b0);
         if (gaps && (p % 3 == 0)) idle(2);
      end
   endtask

   task automatic check_all_reset();
      check("rst_locked", {15'd0, locked}, 16'd0);
      check("rst_err_flag", {15'd0, err_flag}, 16'd0);
      check("rst_err_cnt", err_cnt, 16'd0);
      check("rst_blk_cnt", blk_cnt, 16'd0);
      check("rst_blk_done", {15'd0, blk_done}, 16'd0);
   endtask

   initial begin
      nRST = 1'b0;
      repeat (3) @(negedge clk);
      check_all_reset();
      nRST = 1'b1;
      idle(2);

      // Three clean blocks with headers 0,1,2.
      send(8'd255, 1'b1, 1'b0);
      send(8'd0, 1'b1, 1'b0);
      idle(2);
      check("lock_after_header", {15'd0, locked}, 16'd1);
      expect_blk(16'd1, 16'd0, 1'b0);
      body(256, 0, 1'b0);
      expect_blk(16'd2, 16'd0, 1'b0);
      send(8'd1, 1'b1, 1'b0);
      body(256, 0, 1'b0);
      expect_blk(16'd3, 16'd0, 1'b0);
      send(8'd2, 1'b1, 1'b0);
      body(256, 0, 1'b0);
      idle(2);
      check("clean_err_cnt", err_cnt, 16'd0);

      // Single corruption at position 37, then a clean block.
      expect_blk(16'd4, 16'd1, 1'b1);
      send(8'd3, 1'b1, 1'b0);
      body(37, 37, 1'b0);
      expect_blk(16'd5, 16'd1, 1'b1);
      send(8'd4, 1'b1, 1'b0);
      body(256, 0, 1'b0);
      idle(2);
      check("single_err_cnt", err_cnt, 16'd1);
      check("single_locked", {15'd0, locked}, 16'd1);

      // clr_err alone, then four consecutive mismatches lose lock.
      send(8'd0, 1'b0, 1'b1);
      idle(2);
      check("clr_err_cnt", err_cnt, 16'd0);
      check("clr_err_flag", {15'd0, err_flag}, 16'd0);
      check("clr_keeps_lock", {15'd0, locked}, 16'd1);
      check("clr_keeps_blk", blk_cnt, 16'd5);
      send(8'd5, 1'b1, 1'b0);
      for (int p = 1; p <= 13; p++) send((p >= 10) ? 8'h00 : 8'(p), 1'b1, 1'b0);
      idle(1);
      check("loss_still_locked", {15'd0, locked}, 16'd1);
      idle(1);
      check("loss_unlocked", {15'd0, locked}, 16'd0);
      check("loss_err_cnt", err_cnt, 16'd4);
      send(8'd100, 1'b1, 1'b0);
      idle(2);
      check("sync_no_count", err_cnt, 16'd4);
      check("sync_no_lock", {15'd0, locked}, 16'd0);
      send(8'd255, 1'b1, 1'b0);
      send(8'd7, 1'b1, 1'b0);
      idle(2);
      check("relock", {15'd0, locked}, 16'd1);

      // Gapped block: blk_done only after the 255th valid byte.
      expect_blk(16'd6, 16'd4, 1'b1);
      for (int p = 1; p < 255; p++) begin
         send(8'(p), 1'b1, 1'b0);
         if (p % 2 == 0) idle(2);
      end
      idle(3);
      check("gap_blk_pending", blk_cnt, 16'd5);
      send(8'd255, 1'b1, 1'b0);
      idle(2);
      check("gap_blk_cnt", blk_cnt, 16'd6);
      check("gap_err_cnt", err_cnt, 16'd4);

      // Realign so the expected header is 5, then send 9 in its place.
      send(8'd0, 1'b0, 1'b1);
      send(8'd8, 1'b1, 1'b0);
      for (int p = 1; p <= 4; p++) send(8'h00, 1'b1, 1'b0);
      idle(2);
      check("drop2_unlocked", {15'd0, locked}, 16'd0);
      send(8'd0, 1'b0, 1'b1);
      send(8'd255, 1'b1, 1'b0);
      expect_blk(16'd7, 16'd0, 1'b0);
      send(8'd4, 1'b1, 1'b0);
      body(256, 0, 1'b1);
      expect_blk(16'd8, HDR_ERR, HDR_ERR[0]);
      send(8'd9, 1'b1, 1'b0);
      idle(2);
      check("hdr_err_cnt", err_cnt, HDR_ERR);
      body(256, 0, 1'b0);

      // Seven spaced mismatches, then clear coincident with an eighth.
      send(8'd0, 1'b0, 1'b1);
      send(8'd6, 1'b1, 1'b0);
      for (int p = 1; p <= 14; p++) send((p % 2 == 1) ? 8'h00 : 8'(p), 1'b1, 1'b0);
      idle(2);
      check("seven_err_cnt", err_cnt, 16'd7);
      send(8'h00, 1'b1, 1'b1);
      idle(2);
      check("clr_mis_err_cnt", err_cnt, 16'd1);
      check("clr_mis_err_flag", {15'd0, err_flag}, 16'd1);
      check("clr_mis_locked", {15'd0, locked}, 16'd1);

      // Mid-block reset discards everything; plain data does not relock.
      @(negedge clk);
      nRST = 1'b0;
      data_en = 1'b0;
      clr_err = 1'b0;
      repeat (2) @(negedge clk);
      nRST = 1'b1;
      check_all_reset();
      for (int p = 17; p <= 20; p++) send(8'(p), 1'b1, 1'b0);
      idle(2);
      check("post_rst_locked", {15'd0, locked}, 16'd0);
      check("post_rst_err_cnt", err_cnt, 16'd0);

      idle(4);
      check("sb_drained", 16'(sb.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
